// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types and sizing for the fetch/decode instruction buffer.
package fetch_decode_buffer_pkg;
  localparam int INSTR_W          = 32;
  localparam int PC_W             = 32;
  localparam int THR_PER_CORE     = 4;
  localparam int THR_W            = $clog2(THR_PER_CORE);
  localparam int FDB_DEPTH        = 4;
  localparam int FDB_STALL_MARGIN = 2;
  localparam int FDB_PTR_W        = $clog2(FDB_DEPTH);

  typedef logic [THR_W-1:0] thr_id_t;

  typedef struct packed {
    logic page_fault;
    logic access_fault;
    logic misaligned;
  } fetch_xcpt_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    fetch_xcpt_t        xcpt;
  } fdb_entry_t;
endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side, branch-flush and decode-side signals of the instruction buffer.
interface fetch_decode_buffer_if;
  import fetch_decode_buffer_pkg::*;

  logic                    fetch_valid;
  logic [INSTR_W-1:0]      fetch_data;
  logic [PC_W-1:0]         fetch_pc;
  thr_id_t                 fetch_thr_id;
  fetch_xcpt_t             fetch_xcpt;
  logic [THR_PER_CORE-1:0] stall_fetch;
  logic                    flush;
  thr_id_t                 flush_thr_id;
  logic [THR_PER_CORE-1:0] decode_stall;
  logic                    dec_valid;
  logic [INSTR_W-1:0]      dec_data;
  logic [PC_W-1:0]         dec_pc;
  thr_id_t                 dec_thr_id;
  fetch_xcpt_t             dec_xcpt;

  // master: the fetch/branch/decode environment around the buffer
  modport master (
    output fetch_valid, fetch_data, fetch_pc, fetch_thr_id, fetch_xcpt,
    output flush, flush_thr_id, decode_stall,
    input  stall_fetch, dec_valid, dec_data, dec_pc, dec_thr_id, dec_xcpt
  );

  modport slave (
    input  fetch_valid, fetch_data, fetch_pc, fetch_thr_id, fetch_xcpt,
    input  flush, flush_thr_id, decode_stall,
    output stall_fetch, dec_valid, dec_data, dec_pc, dec_thr_id, dec_xcpt
  );
endinterface

// File: rtl/fdb_thread_fifo.sv
// One thread's instruction queue: storage, wrapping pointers and occupancy count.
module fdb_thread_fifo
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = FDB_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fdb_entry_t             wdata,
  output fdb_entry_t             rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fdb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              wr_en;

  // a flush wins over a same-cycle push; a push to a full queue is dropped
  assign wr_en = push && !flush && (count != CNT_W'(DEPTH));
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_decode_buffer.sv
// Per-thread instruction queues between fetch and decode with round-robin issue.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH        = FDB_DEPTH,
  parameter int STALL_MARGIN = FDB_STALL_MARGIN
) (
  input logic                  clock,
  input logic                  reset,
  fetch_decode_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [THR_PER_CORE-1:0][CNT_W-1:0] count;
  fdb_entry_t [THR_PER_CORE-1:0]      head;
  logic [THR_PER_CORE-1:0]            push, pop, flush_vec, elig;
  fdb_entry_t                         wdata;
  thr_id_t                            rr_ptr, grant, idx;
  logic                               grant_vld;

  assign wdata = '{instr: bus.fetch_data, pc: bus.fetch_pc, xcpt: bus.fetch_xcpt};

  always_comb begin
    for (int t = 0; t < THR_PER_CORE; t++) begin
      push[t]      = bus.fetch_valid && (bus.fetch_thr_id == THR_W'(t));
      flush_vec[t] = bus.flush && (bus.flush_thr_id == THR_W'(t));
      elig[t]      = (count[t] != '0) && !bus.decode_stall[t] && !flush_vec[t];
      pop[t]       = grant_vld && (grant == THR_W'(t));
      bus.stall_fetch[t] = count[t] >= CNT_W'(DEPTH - STALL_MARGIN);
    end
  end

  // scan from farthest to nearest so the thread just after rr_ptr wins last
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = THR_PER_CORE; i >= 1; i--) begin
      idx = rr_ptr + THR_W'(i);
      if (elig[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)          rr_ptr <= '0;
    else if (grant_vld) rr_ptr <= grant;
  end

  always_comb begin
    bus.dec_valid  = grant_vld;
    bus.dec_thr_id = grant_vld ? grant : '0;
    bus.dec_data   = grant_vld ? head[grant].instr : '0;
    bus.dec_pc     = grant_vld ? head[grant].pc    : '0;
    bus.dec_xcpt   = grant_vld ? head[grant].xcpt  : '0;
  end

  for (genvar t = 0; t < THR_PER_CORE; t++) begin : g_thr
    fdb_thread_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[t]),
      .pop   (pop[t]),
      .flush (flush_vec[t]),
      .wdata (wdata),
      .rdata (head[t]),
      .count (count[t])
    );
  end

  // stall_fetch's margin must cover every in-flight fetch; overflow is a design error
  ast_no_full_push: assert property (@(posedge clock) disable iff (reset)
    !(bus.fetch_valid && !flush_vec[bus.fetch_thr_id] &&
      count[bus.fetch_thr_id] == CNT_W'(DEPTH)));
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: directed scenarios plus random traffic vs a queue model.
module tb_fetch_decode_buffer;
  import fetch_decode_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_decode_buffer_if bus();

  fetch_decode_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;
  fdb_entry_t q [THR_PER_CORE][$];
  int rr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit rst, input bit fv, input int thr, input logic [31:0] pc,
                      input logic [31:0] data, input logic [2:0] x, input bit fl,
                      input int fthr, input logic [3:0] ds);
    bit [3:0] el;
    int g;
    bit gv;
    logic [3:0] exp_stall;
    fdb_entry_t e;
    @(negedge clock);
    reset            = rst;
    bus.fetch_valid  = fv;
    bus.fetch_thr_id = thr_id_t'(thr);
    bus.fetch_pc     = pc;
    bus.fetch_data   = data;
    bus.fetch_xcpt   = fetch_xcpt_t'(x);
    bus.flush        = fl;
    bus.flush_thr_id = thr_id_t'(fthr);
    bus.decode_stall = ds;
    #1;
    gv = 0; g = 0;
    for (int t = 0; t < THR_PER_CORE; t++) begin
      el[t] = (q[t].size() != 0) && !ds[t] && !(fl && fthr == t);
      exp_stall[t] = q[t].size() >= (FDB_DEPTH - FDB_STALL_MARGIN);
    end
    for (int i = 1; i <= THR_PER_CORE; i++) begin
      int t = (rr + i) % THR_PER_CORE;
      if (!gv && el[t]) begin gv = 1; g = t; end
    end
    chk("stall_fetch", 64'(bus.stall_fetch), 64'(exp_stall));
    chk("dec_valid", 64'(bus.dec_valid), 64'(gv));
    if (gv) begin
      e = q[g][0];
      chk("dec_thr_id", 64'(bus.dec_thr_id), 64'(g));
      chk("dec_pc", 64'(bus.dec_pc), 64'(e.pc));
      chk("dec_data", 64'(bus.dec_data), 64'(e.instr));
      chk("dec_xcpt", 64'(bus.dec_xcpt), 64'(e.xcpt));
    end else begin
      chk("dec_pc_idle", 64'(bus.dec_pc), 64'd0);
      chk("dec_thr_idle", 64'(bus.dec_thr_id), 64'd0);
    end
    if (rst) begin
      for (int t = 0; t < THR_PER_CORE; t++) q[t].delete();
      rr = 0;
    end else begin
      if (gv) begin void'(q[g].pop_front()); rr = g; end
      if (fl) q[fthr].delete();
      if (fv && !(fl && fthr == thr))
        q[thr].push_back('{instr: data, pc: pc, xcpt: fetch_xcpt_t'(x)});
    end
  endtask

  task automatic idle(input logic [3:0] ds);
    step(0, 0, 0, 0, 0, 0, 0, 0, ds);
  endtask

  task automatic push(input int thr, input logic [31:0] pc, input logic [3:0] ds);
    step(0, 1, thr, pc, ~pc, 3'(pc[4:2]), 0, 0, ds);
  endtask

  initial begin
    bus.fetch_valid = 0; bus.fetch_thr_id = '0; bus.fetch_pc = '0; bus.fetch_data = '0;
    bus.fetch_xcpt = '0; bus.flush = 0; bus.flush_thr_id = '0; bus.decode_stall = '0;
    repeat (2) @(posedge clock);

    // reset state, then two back-to-back pushes on T0
    idle(4'h0);
    push(0, 32'h1000, 4'h0);
    push(0, 32'h1004, 4'h0);
    chk("t1_pc0", 64'(bus.dec_pc), 64'h1000);
    idle(4'h0);
    chk("t1_pc1", 64'(bus.dec_pc), 64'h1004);
    idle(4'h0);

    // stalled decode: stall_fetch after 2 entries, 2 in-flight pushes still land
    for (int i = 0; i < 4; i++) push(0, 32'h2000 + 4 * i, 4'h1);
    chk("t2_stall", 64'(bus.stall_fetch[0]), 64'd1);
    for (int i = 0; i < 5; i++) idle(4'h0);

    // T0/T1 each with 3 entries drain alternately
    for (int i = 0; i < 3; i++) begin
      push(0, 32'h3000 + 4 * i, 4'h3);
      push(1, 32'h3100 + 4 * i, 4'h3);
    end
    for (int i = 0; i < 7; i++) idle(4'h0);

    // flush T1 with a same-cycle T1 push while T0 is stalled
    push(0, 32'h4000, 4'h3);
    push(1, 32'h4100, 4'h3);
    push(1, 32'h4104, 4'h3);
    step(0, 1, 1, 32'h4108, 32'h0, 3'd0, 1, 1, 4'h1);
    chk("t4_flush_nv", 64'(bus.dec_valid), 64'd0);
    idle(4'h1);
    idle(4'h0);
    idle(4'h0);

    // push and pop the same thread in one cycle
    push(0, 32'h5000, 4'h1);
    push(0, 32'h5004, 4'h0);
    idle(4'h0);
    idle(4'h0);

    // reset with all queues populated
    for (int t = 0; t < THR_PER_CORE; t++) begin
      push(t, 32'h6000 + 32'(t) * 16, 4'hF);
      push(t, 32'h6004 + 32'(t) * 16, 4'hF);
    end
    step(1, 1, 2, 32'h6fff, 32'h0, 3'd0, 0, 0, 4'h0);
    idle(4'h0);
    chk("t6_dec_valid", 64'(bus.dec_valid), 64'd0);
    chk("t6_stall", 64'(bus.stall_fetch), 64'd0);

    // random traffic; fetch never overfills a queue
    for (int n = 0; n < 3000; n++) begin
      int thr = $urandom_range(0, THR_PER_CORE - 1);
      bit fv  = ($urandom_range(0, 3) != 0) && (q[thr].size() < FDB_DEPTH);
      bit fl  = ($urandom_range(0, 15) == 0);
      bit rst = ($urandom_range(0, 299) == 0);
      logic [3:0] ds = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      step(rst, fv, thr, $urandom, $urandom, 3'($urandom_range(0, 7)), fl,
           $urandom_range(0, THR_PER_CORE - 1), ds);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
